mem_stage_lsu: RTL and testbench

Parametrised successor to the pass-through MEM stage. It performs MIPS load/store accesses over a req/ack data bus with wait states and byte lanes, and formats load data with sign/zero extension. It includes the MEM/WB pipeline register, so all writeback outputs are registered. While a bus access is outstanding it raises a stall request to the pipeline controller, and it flags misalignment and bus timeout.

---
 rtl/mem_stage_lsu.sv | 275 +++++++++++++++++++++++++++
 tb/tb_mem_stage_lsu.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_stage_lsu.sv
// MEM stage load/store unit: req/ack bus master with byte lanes, load extension and the MEM/WB register.
// Optional LL/SC support is compiled in when MEM_LLSC_EN is defined.
module mem_stage_lsu #(
   parameter int ADDR_W     = 32,
   parameter int REG_ADDR_W = 5,
   parameter int WAIT_MAX   = 16
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  valid_i,
   input  logic [REG_ADDR_W-1:0] wd_i,
   input  logic                  wreg_i,
   input  logic [31:0]           wdata_i,
   input  logic [3:0]            mem_op_i,
   input  logic [ADDR_W-1:0]     mem_addr_i,
   input  logic [31:0]           mem_sdata_i,
   input  logic [31:0]           hi_i,
   input  logic [31:0]           lo_i,
   input  logic                  whilo_i,
   input  logic                  ll_clr_i,
   output logic                  bus_req_o,
   output logic                  bus_we_o,
   output logic [ADDR_W-1:0]     bus_addr_o,
   output logic [3:0]            bus_sel_o,
   output logic [31:0]           bus_wdata_o,
   input  logic [31:0]           bus_rdata_i,
   input  logic                  bus_ack_i,
   output logic                  stall_req_o,
   output logic [REG_ADDR_W-1:0] wd_o,
   output logic                  wreg_o,
   output logic [31:0]           wdata_o,
   output logic [31:0]           hi_o,
   output logic [31:0]           lo_o,
   output logic                  whilo_o,
   output logic                  exc_align_o,
   output logic                  exc_bus_o
);

   localparam logic [3:0] OP_LB  = 4'd1;
   localparam logic [3:0] OP_LBU = 4'd2;
   localparam logic [3:0] OP_LH  = 4'd3;
   localparam logic [3:0] OP_LHU = 4'd4;
   localparam logic [3:0] OP_LW  = 4'd5;
   localparam logic [3:0] OP_SB  = 4'd6;
   localparam logic [3:0] OP_SH  = 4'd7;
   localparam logic [3:0] OP_SW  = 4'd8;
`ifdef MEM_LLSC_EN
   localparam logic [3:0] OP_LL  = 4'd9;
   localparam logic [3:0] OP_SC  = 4'd10;
`endif

   localparam logic [1:0] SZ_B = 2'd0;
   localparam logic [1:0] SZ_H = 2'd1;
   localparam logic [1:0] SZ_W = 2'd2;

   localparam int CNT_W = (WAIT_MAX > 1) ? $clog2(WAIT_MAX) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WAIT_MAX - 1);

   typedef enum logic {IDLE, ACCESS} state_t;

   state_t           state, state_nxt;
   logic [CNT_W-1:0] wait_cnt;

   logic       is_load, is_store, is_sc, mem_op, misalign, sc_fail;
   logic [1:0] sz;
   logic       start, ack_ok, timeout, align_err, sc_fail_go;

   function automatic logic [3:0] lane_sel(input logic [1:0] s, input logic [1:0] lane);
      case (s)
         SZ_B:    lane_sel = 4'b0001 << lane;
         SZ_H:    lane_sel = lane[1] ? 4'b1100 : 4'b0011;
         default: lane_sel = 4'b1111;
      endcase
   endfunction

   function automatic logic [31:0] lane_wdata(input logic [1:0] s, input logic [31:0] d);
      case (s)
         SZ_B:    lane_wdata = {4{d[7:0]}};
         SZ_H:    lane_wdata = {2{d[15:0]}};
         default: lane_wdata = d;
      endcase
   endfunction

   function automatic logic [31:0] load_fmt(input logic [3:0] op, input logic [1:0] lane,
                                            input logic [31:0] rd);
      logic [7:0]  b;
      logic [15:0] h;
      case (lane)
         2'd0:    b = rd[7:0];
         2'd1:    b = rd[15:8];
         2'd2:    b = rd[23:16];
         default: b = rd[31:24];
      endcase
      h = lane[1] ? rd[31:16] : rd[15:0];
      case (op)
         OP_LB:   load_fmt = {{24{b[7]}}, b};
         OP_LBU:  load_fmt = {24'd0, b};
         OP_LH:   load_fmt = {{16{h[15]}}, h};
         OP_LHU:  load_fmt = {16'd0, h};
         default: load_fmt = rd;
      endcase
   endfunction

`ifdef MEM_LLSC_EN
   logic              is_ll;
   logic              ll_bit;
   logic [ADDR_W-1:0] link_addr;
`else
   wire unused_ll_clr = ll_clr_i;
`endif

   always_comb begin
      is_load  = 1'b0;
      is_store = 1'b0;
      is_sc    = 1'b0;
      sz       = SZ_W;
`ifdef MEM_LLSC_EN
      is_ll    = 1'b0;
`endif
      case (mem_op_i)
         OP_LB, OP_LBU: begin is_load  = 1'b1; sz = SZ_B; end
         OP_LH, OP_LHU: begin is_load  = 1'b1; sz = SZ_H; end
         OP_LW:         begin is_load  = 1'b1; sz = SZ_W; end
         OP_SB:         begin is_store = 1'b1; sz = SZ_B; end
         OP_SH:         begin is_store = 1'b1; sz = SZ_H; end
         OP_SW:         begin is_store = 1'b1; sz = SZ_W; end
`ifdef MEM_LLSC_EN
         OP_LL:         begin is_load  = 1'b1; is_ll = 1'b1; sz = SZ_W; end
         OP_SC:         begin is_store = 1'b1; is_sc = 1'b1; sz = SZ_W; end
`endif
         default: ;
      endcase
   end

   assign mem_op   = valid_i & (is_load | is_store);
   assign misalign = ((sz == SZ_H) & mem_addr_i[0]) | ((sz == SZ_W) & (mem_addr_i[1:0] != 2'b00));

`ifdef MEM_LLSC_EN
   assign sc_fail = is_sc & ~(ll_bit & (mem_addr_i == link_addr));
`else
   assign sc_fail = 1'b0;
`endif

   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   always_comb begin
      state_nxt   = state;
      stall_req_o = 1'b0;
      start       = 1'b0;
      ack_ok      = 1'b0;
      timeout     = 1'b0;
      align_err   = 1'b0;
      sc_fail_go  = 1'b0;
      case (state)
         IDLE: begin
            if (mem_op) begin
               if (misalign) begin
                  align_err = 1'b1;
               end else if (sc_fail) begin
                  sc_fail_go = 1'b1;
               end else begin
                  start       = 1'b1;
                  stall_req_o = 1'b1;
                  state_nxt   = ACCESS;
               end
            end
         end
         ACCESS: begin
            // An ack in the last allowed cycle still completes the access.
            if (bus_ack_i) begin
               ack_ok    = 1'b1;
               state_nxt = IDLE;
            end else if (wait_cnt == CNT_LAST) begin
               timeout   = 1'b1;
               state_nxt = IDLE;
            end else begin
               stall_req_o = 1'b1;
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)                                        wait_cnt <= '0;
      else if (state == ACCESS && !ack_ok && !timeout) wait_cnt <= wait_cnt + 1'b1;
      else                                            wait_cnt <= '0;
   end

   // Bus request registers: launched from IDLE, held through ACCESS.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
         bus_addr_o  <= '0;
         bus_sel_o   <= 4'd0;
         bus_wdata_o <= 32'd0;
      end else if (start) begin
         bus_req_o   <= 1'b1;
         bus_we_o    <= is_store;
         bus_addr_o  <= {mem_addr_i[ADDR_W-1:2], 2'b00};
         bus_sel_o   <= lane_sel(sz, mem_addr_i[1:0]);
         bus_wdata_o <= lane_wdata(sz, mem_sdata_i);
      end else if (ack_ok || timeout) begin
         bus_req_o   <= 1'b0;
         bus_we_o    <= 1'b0;
      end
   end

   // MEM/WB register.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         wd_o        <= '0;
         wreg_o      <= 1'b0;
         wdata_o     <= 32'd0;
         hi_o        <= 32'd0;
         lo_o        <= 32'd0;
         whilo_o     <= 1'b0;
         exc_align_o <= 1'b0;
         exc_bus_o   <= 1'b0;
      end else begin
         wd_o        <= wd_i;
         hi_o        <= hi_i;
         lo_o        <= lo_i;
         exc_align_o <= align_err;
         exc_bus_o   <= timeout;
         if (state == IDLE && !mem_op) begin
            wreg_o  <= valid_i & wreg_i;
            whilo_o <= valid_i & whilo_i;
            wdata_o <= wdata_i;
         end else if (sc_fail_go) begin
            wreg_o  <= wreg_i;
            whilo_o <= whilo_i;
            wdata_o <= 32'd0;
         end else if (ack_ok) begin
            whilo_o <= whilo_i;
            if (is_sc) begin
               wreg_o  <= wreg_i;
               wdata_o <= 32'd1;
            end else if (is_load) begin
               wreg_o  <= wreg_i;
               wdata_o <= load_fmt(mem_op_i, mem_addr_i[1:0], bus_rdata_i);
            end else begin
               wreg_o  <= 1'b0;
               wdata_o <= wdata_i;
            end
         end else begin
            wreg_o  <= 1'b0;
            whilo_o <= 1'b0;
            wdata_o <= wdata_i;
         end
      end
   end

`ifdef MEM_LLSC_EN
   // A clear request beats an LL completing in the same cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ll_bit    <= 1'b0;
         link_addr <= '0;
      end else if (ll_clr_i) begin
         ll_bit    <= 1'b0;
      end else if (ack_ok && is_ll) begin
         ll_bit    <= 1'b1;
         link_addr <= mem_addr_i;
      end else if (state == IDLE && mem_op && !misalign && is_sc) begin
         ll_bit    <= 1'b0;
      end
   end
`endif

endmodule

// File: tb/tb_mem_stage_lsu.sv
// Directed bench for mem_stage_lsu: pass-through, loads/stores with wait states, alignment,
// timeout, asynchronous reset mid-access and (with MEM_LLSC_EN) LL/SC.
module tb_mem_stage_lsu;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        valid_i = 1'b0;
   logic [4:0]  wd_i = '0;
   logic        wreg_i = 1'b0;
   logic [31:0] wdata_i = '0;
   logic [3:0]  mem_op_i = '0;
   logic [31:0] mem_addr_i = '0;
   logic [31:0] mem_sdata_i = '0;
   logic [31:0] hi_i = '0;
   logic [31:0] lo_i = '0;
   logic        whilo_i = 1'b0;
   logic        ll_clr_i = 1'b0;
   logic        bus_req_o, bus_we_o;
   logic [31:0] bus_addr_o;
   logic [3:0]  bus_sel_o;
   logic [31:0] bus_wdata_o;
   logic [31:0] bus_rdata_i = '0;
   logic        bus_ack_i = 1'b0;
   logic        stall_req_o;
   logic [4:0]  wd_o;
   logic        wreg_o;
   logic [31:0] wdata_o, hi_o, lo_o;
   logic        whilo_o, exc_align_o, exc_bus_o;

   mem_stage_lsu dut (
      .clk(clk), .rst(rst), .valid_i(valid_i), .wd_i(wd_i), .wreg_i(wreg_i), .wdata_i(wdata_i),
      .mem_op_i(mem_op_i), .mem_addr_i(mem_addr_i), .mem_sdata_i(mem_sdata_i),
      .hi_i(hi_i), .lo_i(lo_i), .whilo_i(whilo_i), .ll_clr_i(ll_clr_i),
      .bus_req_o(bus_req_o), .bus_we_o(bus_we_o), .bus_addr_o(bus_addr_o), .bus_sel_o(bus_sel_o),
      .bus_wdata_o(bus_wdata_o), .bus_rdata_i(bus_rdata_i), .bus_ack_i(bus_ack_i),
      .stall_req_o(stall_req_o), .wd_o(wd_o), .wreg_o(wreg_o), .wdata_o(wdata_o),
      .hi_o(hi_o), .lo_o(lo_o), .whilo_o(whilo_o), .exc_align_o(exc_align_o), .exc_bus_o(exc_bus_o)
   );

   always #5 clk = ~clk;

   int n_chk  = 0;
   int n_fail = 0;

   logic        cap_req, cap_we;
   logic [3:0]  cap_sel;
   logic [31:0] cap_addr, cap_wdata;
   int          stalls, cnt;
   logic        last_stall;

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_op(input logic [3:0] op, input logic [31:0] addr, input logic [31:0] sd);
      valid_i     = 1'b1;
      wreg_i      = 1'b1;
      mem_op_i    = op;
      mem_addr_i  = addr;
      mem_sdata_i = sd;
   endtask

   // Runs one bus access from IDLE: nwait cycles without ack, then ack with rd.
   task automatic mem_xfer(input int nwait, input logic [31:0] rd, output int st);
      st = 0;
      #1;
      if (stall_req_o) st++;
      tick();
      cap_req = bus_req_o; cap_we = bus_we_o; cap_sel = bus_sel_o;
      cap_addr = bus_addr_o; cap_wdata = bus_wdata_o;
      repeat (nwait) begin
         if (stall_req_o) st++;
         tick();
      end
      bus_rdata_i = rd;
      bus_ack_i   = 1'b1;
      #1;
      if (stall_req_o) st++;
      tick();
      bus_ack_i = 1'b0;
      mem_op_i  = 4'd0;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout, expected end of test");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      tick(); tick();
      check_eq("rst_bus_req", 32'(bus_req_o), 32'd0);
      check_eq("rst_wreg",    32'(wreg_o),    32'd0);
      check_eq("rst_wd",      32'(wd_o),      32'd0);
      check_eq("rst_wdata",   wdata_o,        32'd0);
      check_eq("rst_stall",   32'(stall_req_o), 32'd0);
      rst = 1'b0;
      tick();

      // ALU pass-through
      valid_i = 1'b1; mem_op_i = 4'd0; wd_i = 5'd3; wreg_i = 1'b1; wdata_i = 32'h1234;
      hi_i = 32'h11; lo_i = 32'h22; whilo_i = 1'b1;
      #1;
      check_eq("alu_stall", 32'(stall_req_o), 32'd0);
      tick();
      check_eq("alu_wd",    32'(wd_o),    32'd3);
      check_eq("alu_wdata", wdata_o,      32'h1234);
      check_eq("alu_wreg",  32'(wreg_o),  32'd1);
      check_eq("alu_hi",    hi_o,         32'h11);
      check_eq("alu_whilo", 32'(whilo_o), 32'd1);
      valid_i = 1'b0;
      tick();
      check_eq("novalid_wreg",  32'(wreg_o),  32'd0);
      check_eq("novalid_whilo", 32'(whilo_o), 32'd0);
      whilo_i = 1'b0;

      // LB 0x103, two wait states
      wd_i = 5'd5;
      set_op(4'd1, 32'h103, 32'd0);
      mem_xfer(2, 32'h80FF_FFFF, stalls);
      check_eq("lb_stalls", 32'(stalls), 32'd3);
      check_eq("lb_req",    32'(cap_req), 32'd1);
      check_eq("lb_we",     32'(cap_we),  32'd0);
      check_eq("lb_sel",    32'(cap_sel), 32'h8);
      check_eq("lb_addr",   cap_addr,     32'h100);
      check_eq("lb_wdata",  wdata_o,      32'hFFFF_FF80);
      check_eq("lb_wreg",   32'(wreg_o),  32'd1);
      check_eq("lb_wd",     32'(wd_o),    32'd5);
      check_eq("lb_req_off", 32'(bus_req_o), 32'd0);

      // LBU same address, ack on first ACCESS cycle
      set_op(4'd2, 32'h103, 32'd0);
      mem_xfer(0, 32'h80FF_FFFF, stalls);
      check_eq("lbu_stalls", 32'(stalls), 32'd1);
      check_eq("lbu_wdata",  wdata_o,     32'h0000_0080);

      // LH upper half, sign extension
      set_op(4'd3, 32'h102, 32'd0);
      mem_xfer(1, 32'h8001_1234, stalls);
      check_eq("lh_sel",   32'(cap_sel), 32'hC);
      check_eq("lh_wdata", wdata_o,      32'hFFFF_8001);

      // LHU lower half, zero extension
      set_op(4'd4, 32'h100, 32'd0);
      mem_xfer(0, 32'h1234_F00D, stalls);
      check_eq("lhu_sel",   32'(cap_sel), 32'h3);
      check_eq("lhu_wdata", wdata_o,      32'h0000_F00D);

      // SH 0x202
      set_op(4'd7, 32'h202, 32'h0000_ABCD);
      mem_xfer(1, 32'd0, stalls);
      check_eq("sh_addr",  cap_addr,               32'h200);
      check_eq("sh_sel",   32'(cap_sel),           32'hC);
      check_eq("sh_we",    32'(cap_we),            32'd1);
      check_eq("sh_lanes", 32'(cap_wdata[31:16]),  32'hABCD);
      check_eq("sh_wreg",  32'(wreg_o),            32'd0);

      // SB 0x101
      set_op(4'd6, 32'h101, 32'h0000_005A);
      mem_xfer(0, 32'd0, stalls);
      check_eq("sb_sel",  32'(cap_sel),          32'h2);
      check_eq("sb_lane", 32'(cap_wdata[15:8]),  32'h5A);

      // LW misaligned
      set_op(4'd5, 32'h101, 32'd0);
      #1;
      check_eq("align_stall", 32'(stall_req_o), 32'd0);
      tick();
      mem_op_i = 4'd0;
      check_eq("align_exc",  32'(exc_align_o), 32'd1);
      check_eq("align_wreg", 32'(wreg_o),      32'd0);
      check_eq("align_req",  32'(bus_req_o),   32'd0);
      tick();
      check_eq("align_pulse", 32'(exc_align_o), 32'd0);

      // Timeout: never ack
      set_op(4'd5, 32'h300, 32'd0);
      #1;
      tick();
      cnt = 0;
      last_stall = 1'b1;
      while (bus_req_o && cnt < 40) begin
         cnt++;
         last_stall = stall_req_o;
         tick();
      end
      mem_op_i = 4'd0;
      #1;
      check_eq("to_req_cycles", 32'(cnt),        32'd16);
      check_eq("to_stall_drop", 32'(last_stall), 32'd0);
      check_eq("to_exc",        32'(exc_bus_o),  32'd1);
      check_eq("to_wreg",       32'(wreg_o),     32'd0);
      check_eq("to_idle_stall", 32'(stall_req_o), 32'd0);
      tick();
      check_eq("to_pulse", 32'(exc_bus_o), 32'd0);

      // Asynchronous reset mid-access; late ack ignored
      set_op(4'd5, 32'h500, 32'd0);
      #1;
      tick();
      check_eq("ra_req_on", 32'(bus_req_o), 32'd1);
      #2 rst = 1'b1;
      #1;
      check_eq("ra_req_drop", 32'(bus_req_o), 32'd0);
      mem_op_i  = 4'd0;
      bus_ack_i = 1'b1;
      tick();
      rst = 1'b0;
      tick();
      check_eq("ra_ack_ignored", 32'(bus_req_o), 32'd0);
      check_eq("ra_no_exc",      32'(exc_bus_o), 32'd0);
      bus_ack_i = 1'b0;

`ifdef MEM_LLSC_EN
      // LL then SC at the same address succeeds
      set_op(4'd9, 32'h40, 32'd0);
      mem_xfer(0, 32'h0000_DEAD, stalls);
      check_eq("ll_wdata", wdata_o,     32'h0000_DEAD);
      check_eq("ll_wreg",  32'(wreg_o), 32'd1);
      set_op(4'd10, 32'h40, 32'h77);
      mem_xfer(0, 32'd0, stalls);
      check_eq("sc_we",    32'(cap_we),  32'd1);
      check_eq("sc_wdata", wdata_o,      32'd1);
      check_eq("sc_wreg",  32'(wreg_o),  32'd1);

      // LL, clear, SC fails without a bus access
      set_op(4'd9, 32'h40, 32'd0);
      mem_xfer(0, 32'h1, stalls);
      ll_clr_i = 1'b1;
      tick();
      ll_clr_i = 1'b0;
      set_op(4'd10, 32'h40, 32'h77);
      #1;
      check_eq("scf_stall", 32'(stall_req_o), 32'd0);
      tick();
      mem_op_i = 4'd0;
      check_eq("scf_wdata", wdata_o,        32'd0);
      check_eq("scf_wreg",  32'(wreg_o),    32'd1);
      check_eq("scf_req",   32'(bus_req_o), 32'd0);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
